// File: rtl/spi_master.sv
// spi_master: byte-framed SPI master, mode 0 (CPOL=0, CPHA=0), full duplex.
// Shifts one byte out on MOSI while it shifts one byte in from MISO. Bytes
// stream back-to-back for as long as CS_n_i stays low and rdy is high.
// SCK half-period is CLK_DIV system clock cycles.
//
// Compile-time option:
//   SPI_LSB_FIRST_EN  - when defined, LSB first in both directions;
//                       when undefined (default), MSB first.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] MOSI_data,
  input  logic       CS_n_i,
  input  logic       rdy,
  output logic [7:0] MISO_data,
  output logic       loadData,
  input  logic       MISO,
  output logic       MOSI,
  output logic       SCK,
  output logic       CS_n
);

  // Half-period counter runs from 0 to CLK_DIV-1.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_WAIT  = 2'd2,
    ST_TRAIL = 2'd3
  } state_t;

  // Bit-order helpers: the only place where the shift direction differs.
`ifdef SPI_LSB_FIRST_EN
  function automatic logic lead_bit(input logic [7:0] b);
    return b[0];
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] b, input logic bit_in);
    return {bit_in, b[7:1]};
  endfunction
`else
  function automatic logic lead_bit(input logic [7:0] b);
    return b[7];
  endfunction

  function automatic logic [7:0] tx_shift(input logic [7:0] b);
    return {b[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] rx_shift(input logic [7:0] b, input logic bit_in);
    return {b[6:0], bit_in};
  endfunction
`endif

  state_t           state_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       tx_reg;
  logic [7:0]       rx_reg;
  logic [7:0]       miso_data_reg;
  logic             load_data_reg;
  logic             mosi_reg;
  logic             sck_reg;
  logic             cs_n_reg;

  logic load_req;
  logic div_last;

  // A byte may be captured whenever the request is active and data is valid.
  assign load_req = !CS_n_i && rdy;
  assign div_last = (div_cnt_reg == DIV_LAST);

  // Frame sequencer: SCK generation, both shifters and all serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      div_cnt_reg   <= '0;
      bit_cnt_reg   <= '0;
      tx_reg        <= '0;
      rx_reg        <= '0;
      miso_data_reg <= '0;
      load_data_reg <= 1'b0;
      mosi_reg      <= 1'b1;
      sck_reg       <= 1'b0;
      cs_n_reg      <= 1'b1;
    end else begin
      // loadData is a single-cycle strobe; only a load cycle raises it.
      load_data_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          div_cnt_reg <= '0;
          bit_cnt_reg <= '0;
          if (load_req) begin
            // Select the slave and present the first bit on the load edge.
            tx_reg        <= MOSI_data;
            mosi_reg      <= lead_bit(MOSI_data);
            load_data_reg <= 1'b1;
            cs_n_reg      <= 1'b0;
            state_reg     <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (div_last) begin
            div_cnt_reg <= '0;
            if (!sck_reg) begin
              // Rising SCK: slave data is sampled here (mode 0).
              sck_reg <= 1'b1;
              rx_reg  <= rx_shift(rx_reg, MISO);
            end else begin
              // Falling SCK: either advance MOSI or close the byte.
              sck_reg <= 1'b0;
              if (bit_cnt_reg == 3'd7) begin
                bit_cnt_reg   <= '0;
                miso_data_reg <= rx_reg;
                if (load_req) begin
                  // Back-to-back byte with no SCK gap.
                  tx_reg        <= MOSI_data;
                  mosi_reg      <= lead_bit(MOSI_data);
                  load_data_reg <= 1'b1;
                end else if (!CS_n_i) begin
                  // Keep the slave selected and MOSI steady until data arrives.
                  state_reg <= ST_WAIT;
                end else begin
                  state_reg <= ST_TRAIL;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                tx_reg      <= tx_shift(tx_reg);
                mosi_reg    <= lead_bit(tx_shift(tx_reg));
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        ST_WAIT: begin
          div_cnt_reg <= '0;
          if (CS_n_i) begin
            state_reg <= ST_TRAIL;
          end else if (rdy) begin
            tx_reg        <= MOSI_data;
            mosi_reg      <= lead_bit(MOSI_data);
            load_data_reg <= 1'b1;
            bit_cnt_reg   <= '0;
            state_reg     <= ST_SHIFT;
          end
        end

        ST_TRAIL: begin
          // Hold CS_n low for one half-period after the last SCK fall.
          if (div_last) begin
            div_cnt_reg <= '0;
            cs_n_reg    <= 1'b1;
            mosi_reg    <= 1'b1;
            state_reg   <= ST_IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign MISO_data = miso_data_reg;
  assign loadData  = load_data_reg;
  assign MOSI      = mosi_reg;
  assign SCK       = sck_reg;
  assign CS_n      = cs_n_reg;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master. Stimulus pushes the byte
// each side should receive; a negedge monitor acts as the SPI slave, checks
// timing against the half-period H, and pops/compares on every byte end.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int H     = 2;
  localparam int LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] MOSI_data = 8'h00;
  logic       CS_n_i = 1'b1;
  logic       rdy = 1'b0;
  logic       MISO = 1'b0;
  logic [7:0] MISO_data;
  logic       loadData;
  logic       MOSI;
  logic       SCK;
  logic       CS_n;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .MOSI_data (MOSI_data),
    .CS_n_i    (CS_n_i),
    .rdy       (rdy),
    .MISO_data (MISO_data),
    .loadData  (loadData),
    .MISO      (MISO),
    .MOSI      (MOSI),
    .SCK       (SCK),
    .CS_n      (CS_n)
  );

  // Scoreboard queues
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_miso_q[$];
  logic       slave_bits_q[$];
  int         load_cyc_q[$];
  int         sck_rise_total = 0;
  int         cs_rise_total  = 0;
  int         load_total     = 0;

  logic [7:0] tx_bytes[4];
  logic [7:0] sl_bytes[4];

  function automatic void check_eq(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endfunction

  function automatic logic lead_bit(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  // Monitor / slave model
  int         cyc = 0;
  int         load_cyc = 0;
  int         last_fall = 0;
  int         rises = 0;
  int         falls = 0;
  bit         byte_active = 1'b0;
  logic       prev_sck = 1'b0;
  logic       prev_cs_n = 1'b1;
  logic       prev_load = 1'b0;
  logic [7:0] slave_rx = 8'h00;
  logic [7:0] e_m;
  logic [7:0] e_t;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_tx_q.delete();
      exp_miso_q.delete();
      slave_bits_q.delete();
      byte_active = 1'b0;
      rises = 0;
      falls = 0;
    end else begin
      // Falling SCK: the 8th one closes the byte.
      if (prev_sck && !SCK) begin
        falls++;
        if (falls == 8) begin
          check_eq("byte_duration", cyc - load_cyc, 16 * H);
          if (exp_miso_q.size() > 0 && exp_tx_q.size() > 0) begin
            e_m = exp_miso_q.pop_front();
            e_t = exp_tx_q.pop_front();
            check_eq("miso_data", int'(MISO_data), int'(e_m));
            check_eq("slave_rx", int'(slave_rx), int'(e_t));
            $display("[%0t] byte: master sent %02h slave got %02h | slave sent %02h MISO_data %02h",
                     $time, e_t, slave_rx, e_m, MISO_data);
          end else begin
            check_eq("byte_without_expectation", 0, 1);
          end
          byte_active = 1'b0;
          last_fall   = cyc;
        end
      end
      // Rising SCK: slave captures MOSI and shifts its next bit onto MISO.
      if (!prev_sck && SCK) begin
        sck_rise_total++;
        check_eq("cs_low_at_rise", int'(CS_n), 0);
        check_eq("rise_inside_byte", int'(byte_active && rises < 8), 1);
        if (byte_active && rises < 8) begin
          if (rises == 0) check_eq("load_to_first_rise", cyc - load_cyc, H);
`ifdef SPI_LSB_FIRST_EN
          slave_rx = {MOSI, slave_rx[7:1]};
`else
          slave_rx = {slave_rx[6:0], MOSI};
`endif
          rises++;
        end
        if (slave_bits_q.size() > 0) void'(slave_bits_q.pop_front());
      end
      if (CS_n && !prev_cs_n) begin
        cs_rise_total++;
        check_eq("last_fall_to_cs_rise", cyc - last_fall, H);
        check_eq("cs_rise_mid_byte", int'(byte_active), 0);
      end
      if (loadData) begin
        load_total++;
        load_cyc_q.push_back(cyc);
        check_eq("load_pulse_width", int'(prev_load), 0);
        check_eq("cs_low_at_load", int'(CS_n), 0);
        check_eq("load_overlaps_byte", int'(byte_active), 0);
        if (exp_tx_q.size() > 0)
          check_eq("mosi_first_bit", int'(MOSI), int'(lead_bit(exp_tx_q[0])));
        else
          check_eq("unexpected_load", 0, 1);
        byte_active = 1'b1;
        load_cyc    = cyc;
        rises       = 0;
        falls       = 0;
        slave_rx    = 8'h00;
      end
    end
    MISO      = (slave_bits_q.size() > 0) ? slave_bits_q[0] : 1'b0;
    prev_sck  = SCK;
    prev_cs_n = CS_n;
    prev_load = loadData;
  end

  // Stimulus helpers
  task automatic issue(input logic [7:0] tx, input logic [7:0] sl);
    MOSI_data = tx;
    rdy       = 1'b1;
    exp_tx_q.push_back(tx);
    exp_miso_q.push_back(sl);
    for (int i = 0; i < 8; i++) begin
`ifdef SPI_LSB_FIRST_EN
      slave_bits_q.push_back(sl[i]);
`else
      slave_bits_q.push_back(sl[7-i]);
`endif
    end
  endtask

  task automatic wait_load();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!loadData && n < LIMIT);
    check_eq("load_timeout", int'(loadData), 1);
  endtask

  task automatic wait_cs_high();
    int n = 0;
    while (!CS_n && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("cs_release_timeout", int'(CS_n), 1);
    @(posedge clk); #1;
  endtask

  task automatic frame(input int nbytes, input int gap_max);
    int gap;
    CS_n_i = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      issue(tx_bytes[i], sl_bytes[i]);
      wait_load();
      if (i == nbytes - 1) begin
        rdy    = 1'b0;
        CS_n_i = 1'b1;
      end else begin
        gap = int'($urandom_range(0, gap_max));
        if (gap > 0) begin
          rdy = 1'b0;
          for (int g = 0; g < gap; g++) begin
            MOSI_data = 8'($urandom);
            @(posedge clk); #1;
          end
        end
      end
    end
    wait_cs_high();
  endtask

  initial begin
    int l0, r0, c0, k0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cs_n", int'(CS_n), 1);
    check_eq("rst_sck", int'(SCK), 0);
    check_eq("rst_mosi", int'(MOSI), 1);
    check_eq("rst_load", int'(loadData), 0);
    check_eq("rst_miso_data", int'(MISO_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single byte CD, slave answers 63
    l0 = load_total; r0 = sck_rise_total;
    tx_bytes[0] = 8'hCD; sl_bytes[0] = 8'h63;
    frame(1, 0);
    check_eq("single_load_count", load_total - l0, 1);
    check_eq("single_rise_count", sck_rise_total - r0, 8);
    check_eq("single_miso_data", int'(MISO_data), 8'h63);

    // Streaming CD A5 0F with no gaps
    l0 = load_total; r0 = sck_rise_total; c0 = cs_rise_total; k0 = load_cyc_q.size();
    tx_bytes[0] = 8'hCD; tx_bytes[1] = 8'hA5; tx_bytes[2] = 8'h0F;
    for (int i = 0; i < 3; i++) sl_bytes[i] = 8'($urandom);
    frame(3, 0);
    check_eq("stream_load_count", load_total - l0, 3);
    check_eq("stream_rise_count", sck_rise_total - r0, 24);
    check_eq("stream_cs_rises", cs_rise_total - c0, 1);
    for (int i = k0; i + 1 < load_cyc_q.size(); i++)
      check_eq("stream_load_spacing", load_cyc_q[i+1] - load_cyc_q[i], 16 * H);

    // Flow control: rdy drops during byte 1, returns 10 cycles into WAIT
    CS_n_i = 1'b0;
    issue(8'h3C, 8'hC3);
    wait_load();
    rdy = 1'b0;
    MOSI_data = 8'hFF;
    repeat (16 * H + 2) @(posedge clk);
    #1;
    check_eq("wait_sck_low", int'(SCK), 0);
    check_eq("wait_cs_low", int'(CS_n), 0);
    check_eq("wait_byte1_miso", int'(MISO_data), 8'hC3);
    repeat (10) @(posedge clk);
    #1;
    check_eq("wait_sck_still_low", int'(SCK), 0);
    check_eq("wait_cs_still_low", int'(CS_n), 0);
    issue(8'h96, 8'h69);
    wait_load();
    rdy = 1'b0;
    CS_n_i = 1'b1;
    wait_cs_high();
    check_eq("flow_byte2_miso", int'(MISO_data), 8'h69);

    // Bit-order corner: 01 out, 80 in
    tx_bytes[0] = 8'h01; sl_bytes[0] = 8'h80;
    frame(1, 0);
    check_eq("order_miso_data", int'(MISO_data), 8'h80);

    // Randomized frames with random rdy gaps
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 4; i++) begin
        tx_bytes[i] = 8'($urandom);
        sl_bytes[i] = 8'($urandom);
      end
      frame(int'($urandom_range(1, 4)), 40);
    end

    // Reset mid-byte
    sl_bytes[0] = 8'hA5;
    CS_n_i = 1'b0;
    issue(8'h5A, sl_bytes[0]);
    wait_load();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    CS_n_i = 1'b1;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("abort_cs_n", int'(CS_n), 1);
    check_eq("abort_sck", int'(SCK), 0);
    check_eq("abort_mosi", int'(MOSI), 1);
    check_eq("abort_load", int'(loadData), 0);
    check_eq("abort_miso_data", int'(MISO_data), 0);
    @(posedge clk); #1;
    check_eq("post_abort_cs_n", int'(CS_n), 1);

    // Recovery after abort
    tx_bytes[0] = 8'h81; sl_bytes[0] = 8'h7E;
    frame(1, 0);
    check_eq("recover_miso_data", int'(MISO_data), 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
